// File: rtl/imem_loader_pkg.sv
// Shared parameters, state encoding and write-port payload for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANES      = DATA_W / BYTE_W;
  localparam int unsigned LANE_IDX_W = 2;
  // One extra bit so a full-depth count can be compared against the word index.
  localparam int unsigned IDX_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } imem_wr_t;

  // A load request is legal for 1..DEPTH words.
  function automatic logic count_legal(input logic [IDX_W-1:0] n);
    return (n != '0) && (n <= IDX_W'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; lane counter wraps after each word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_full_c,
  output logic [DATA_W-1:0] word_nxt_c
);

  logic [LANE_IDX_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     lane_q, lane_d;

  // Current lanes with the incoming byte dropped into the next free lane.
  always_comb begin
    word_nxt_c = lane_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (cnt_q == LANE_IDX_W'(k)) begin
        word_nxt_c[k*BYTE_W +: BYTE_W] = byte_data;
      end
    end
  end

  // High when the next accepted byte completes the word.
  assign word_full_c = (cnt_q == LANE_IDX_W'(LANES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    lane_d = lane_q;
    if (clr) begin
      cnt_d  = '0;
      lane_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + LANE_IDX_W'(1);
      lane_d = word_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lane_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into consecutive instruction-memory words while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ld_state_e         state_q, state_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  imem_wr_t          wr_q, wr_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              pk_clr;
  logic              pk_accept;
  logic              pk_full_c;
  logic [DATA_W-1:0] pk_word_c;

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (pk_clr),
    .accept      (pk_accept),
    .byte_data   (byte_data),
    .word_full_c (pk_full_c),
    .word_nxt_c  (pk_word_c)
  );

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pk_clr    = 1'b0;
    pk_accept = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          if (count_legal(word_count)) begin
            count_d = word_count;
            idx_d   = '0;
            pk_clr  = 1'b1;
            state_d = LD_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LD_RECV: begin
        if (abort) begin
          state_d = LD_IDLE;
          err_d   = 1'b1;
          pk_clr  = 1'b1;
        end else if (byte_valid && ready_q) begin
          pk_accept = 1'b1;
          if (pk_full_c) begin
            state_d    = LD_WRITE;
            we_d       = 1'b1;
            wr_d.addr  = idx_q[ADDR_W-1:0];
            wr_d.wdata = pk_word_c;
          end
        end
      end
      LD_WRITE: begin
        if (abort) begin
          state_d = LD_IDLE;
          err_d   = 1'b1;
          pk_clr  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_d == count_q) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LD_RECV;
          end
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
        err_d   = abort;
      end
      default: state_d = LD_IDLE;
    endcase

    ready_d = (state_d == LD_RECV);
    busy_d  = (state_d != LD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // An abort arriving in the write or done cycle cancels that cycle's strobe.
  assign mem_we     = we_q && !abort;
  assign done       = done_q && !abort;
  assign mem_addr   = wr_q.addr;
  assign mem_wdata  = wr_q.wdata;
  assign byte_ready = ready_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle model of the load protocol plus literal memory checks.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [IDX_W-1:0]  word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_we = 0, n_done = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Behavioural model: a load is active, collects bytes four at a time, then spends one
  // cycle writing and, after the last word, one cycle signalling done.
  bit         m_active = 0, m_write_now = 0, m_done_now = 0, m_err_now = 0;
  int         m_cnt = 0, m_widx = 0, m_nb = 0;
  logic [7:0] m_lane [3];
  logic [5:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_write_now <= 0; m_done_now <= 0; m_err_now <= 0;
      m_cnt <= 0; m_widx <= 0; m_nb <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_write_now <= 0; m_done_now <= 0; m_err_now <= 0;
      if (!m_active) begin
        if (start) begin
          if (word_count >= 1 && int'(word_count) <= int'(DEPTH)) begin
            m_active <= 1; m_cnt <= int'(word_count); m_widx <= 0; m_nb <= 0;
          end else begin
            m_err_now <= 1;
          end
        end
      end else if (abort) begin
        m_active <= 0; m_err_now <= 1; m_nb <= 0;
      end else if (m_write_now) begin
        m_widx <= m_widx + 1;
        if (m_widx + 1 == m_cnt) m_done_now <= 1;
      end else if (m_done_now) begin
        m_active <= 0;
      end else if (byte_valid) begin
        if (m_nb == 3) begin
          m_data <= {byte_data, m_lane[2], m_lane[1], m_lane[0]};
          m_addr <= 6'(m_widx);
          m_write_now <= 1;
          m_nb <= 0;
        end else begin
          m_lane[m_nb] <= byte_data;
          m_nb <= m_nb + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(m_active && !m_write_now && !m_done_now));
    chk("busy",       32'(busy),       32'(m_active));
    chk("cpu_hold",   32'(cpu_hold),   32'(m_active));
    chk("mem_we",     32'(mem_we),     32'(m_write_now && !abort));
    chk("done",       32'(done),       32'(m_done_now && !abort));
    chk("err",        32'(err),        32'(m_err_now));
    chk("mem_addr",   32'(mem_addr),   32'(m_addr));
    chk("mem_wdata",  mem_wdata,       m_data);
    if (mem_we) n_we++;
    if (done)   n_done++;
    if (err)    n_err++;
  end

  // Stand-in instruction memory observed through the write port.
  logic [31:0] tb_mem [DEPTH];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] <= 32'hDEADBEEF;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    word_count = IDX_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int guard, gaps;
    acc = 0; guard = 0; gaps = 0;
    if (rnd) begin
      while (gaps < 4 && $urandom_range(1, 0) == 0) begin
        byte_valid = 1'b0;
        tick();
        gaps++;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!acc) begin
      acc = byte_ready;
      tick();
      guard++;
      if (!acc && guard > 40) begin
        timeout_fail("byte_accept");
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], rnd);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    if (busy) timeout_fail("wait_idle");
  endtask

  int we0, dn0, er0;

  task automatic snap();
    we0 = n_we; dn0 = n_done; er0 = n_err;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hold", 32'(cpu_hold), 32'd0);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    clear_mem();

    // Basic three-word load.
    snap();
    do_start(3);
    send_word(32'h00000013, 0);
    send_word(32'h00100093, 0);
    send_word(32'h00000133, 0);
    wait_idle();
    tick();
    chk("t1_mem0", tb_mem[0], 32'h00000013);
    chk("t1_mem1", tb_mem[1], 32'h00100093);
    chk("t1_mem2", tb_mem[2], 32'h00000133);
    chk("t1_we_count", 32'(n_we - we0), 32'd3);
    chk("t1_done_count", 32'(n_done - dn0), 32'd1);
    chk("t1_hold_after", 32'(cpu_hold), 32'd0);

    // Bursty source.
    clear_mem();
    snap();
    do_start(2);
    send_word(32'h00000013, 1);
    send_word(32'h00100093, 1);
    wait_idle();
    tick();
    chk("t2_mem0", tb_mem[0], 32'h00000013);
    chk("t2_mem1", tb_mem[1], 32'h00100093);
    chk("t2_we_count", 32'(n_we - we0), 32'd2);

    // Illegal counts.
    snap();
    do_start(0);
    tick();
    do_start(65);
    tick();
    chk("t3_err_count", 32'(n_err - er0), 32'd2);
    chk("t3_we_count", 32'(n_we - we0), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // Abort mid-word after six bytes.
    clear_mem();
    snap();
    do_start(4);
    send_word(32'h44332211, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("t4_mem0", tb_mem[0], 32'h44332211);
    chk("t4_mem1", tb_mem[1], 32'hDEADBEEF);
    chk("t4_we_count", 32'(n_we - we0), 32'd1);
    chk("t4_err_count", 32'(n_err - er0), 32'd1);
    chk("t4_done_count", 32'(n_done - dn0), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // Abort in the write cycle suppresses that write.
    clear_mem();
    snap();
    do_start(2);
    send_word(32'hCAFEF00D, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("t4b_mem0", tb_mem[0], 32'hDEADBEEF);
    chk("t4b_we_count", 32'(n_we - we0), 32'd0);
    chk("t4b_err_count", 32'(n_err - er0), 32'd1);

    // Asynchronous reset mid-load, then a fresh load from lane 0.
    clear_mem();
    do_start(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd0);
    chk("t5_ready", 32'(byte_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    snap();
    do_start(1);
    send_word(32'hDDCCBBAA, 0);
    wait_idle();
    tick();
    chk("t5_mem0", tb_mem[0], 32'hDDCCBBAA);
    chk("t5_we_count", 32'(n_we - we0), 32'd1);

    // Full-depth load with a stray start in the middle.
    clear_mem();
    snap();
    do_start(64);
    for (int i = 0; i < 64; i++) begin
      send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 0);
      if (i == 10) begin
        start = 1'b1;
        word_count = IDX_W'(5);
        tick();
        start = 1'b0;
      end
    end
    wait_idle();
    tick();
    chk("t6_mem0", tb_mem[0], 32'h03020100);
    chk("t6_mem31", tb_mem[31], 32'h7F7E7D7C);
    chk("t6_mem63", tb_mem[63], 32'hFFFEFDFC);
    chk("t6_we_count", 32'(n_we - we0), 32'd64);
    chk("t6_done_count", 32'(n_done - dn0), 32'd1);
    chk("t6_err_count", 32'(n_err - er0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
